a2g_tx_frame_gate: RTL and testbench

// Packet-boundary gate that applies the software tx_en control word to the a2g photon stream heading to the 10GbE TX FIFO.

---
 rtl/a2g_pkg.sv | 27 ++
 rtl/a2g_frame_counter.sv | 29 ++
 rtl/a2g_tx_frame_gate.sv | 262 ++++++++++++++++++++++++++
 tb/tb_a2g_tx_frame_gate.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/a2g_pkg.sv
// Shared definitions for the a2g TX frame gate: FSM state encoding,
// control-word bit positions and error-flag bit positions.
package a2g_pkg;

   // Gate FSM states; the encoding is visible to software through state_dbg.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_PASS  = 2'd2,
      ST_DROP  = 2'd3
   } a2g_state_t;

   // ctrl_word bit positions
   localparam int CTRL_TX_EN   = 0;
   localparam int CTRL_CNT_CLR = 1;
   localparam int CTRL_ERR_CLR = 2;

   // err_sticky bit positions
   localparam int ERR_READY = 0;   // tx_ready low while a frame was being forwarded
   localparam int ERR_LEN   = 1;   // frame too long or missing its eof

   // Rising-edge detect of a level against its registered copy.
   function automatic logic rise_edge(input logic cur, input logic prev);
      return cur & ~prev;
   endfunction

endpackage

// File: rtl/a2g_frame_counter.sv
// Wrapping event counter with synchronous clear; clear beats increment.
module a2g_frame_counter #(
   parameter int CNT_W = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_inc,
   input  logic             i_clr,
   output logic [CNT_W-1:0] o_count
);

   logic [CNT_W-1:0] r_count;

   // Count events, wrapping modulo 2^CNT_W; a clear in the same cycle discards the increment.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= {CNT_W{1'b0}};
      end else if (i_clr) begin
         r_count <= {CNT_W{1'b0}};
      end else if (i_inc) begin
         r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         r_count <= r_count;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/a2g_tx_frame_gate.sv
// Packet-boundary gate between the photon packetizer and the 10GbE TX FIFO.
// tx_en only takes effect between frames, over-long or unterminated frames
// are force-closed, and sent/dropped frames are counted for software.
module a2g_tx_frame_gate
   import a2g_pkg::*;
#(
   parameter int DATA_W          = 64,
   parameter int CNT_W           = 32,
   parameter int MAX_FRAME_WORDS = 128
) (
   input  logic              user_clk,
   input  logic              user_rst_n,
   input  logic [31:0]       ctrl_word,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_sof,
   input  logic              in_eof,
   input  logic              tx_ready,
   output logic              tx_valid,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_sof,
   output logic              tx_eof,
   output logic [CNT_W-1:0]  frames_sent,
   output logic [CNT_W-1:0]  frames_drop,
   output logic [1:0]        err_sticky,
   output logic [1:0]        state_dbg
);

   localparam int LEN_W = $clog2(MAX_FRAME_WORDS + 1);
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_FRAME_WORDS);
   localparam logic [LEN_W-1:0] ONE_LEN = LEN_W'(1);

   a2g_state_t        r_state;
   a2g_state_t        w_state_nxt;
   logic [LEN_W-1:0]  r_len;
   logic [LEN_W-1:0]  w_len_nxt;
   logic [LEN_W-1:0]  w_len_inc;
   logic              r_in_open;
   logic              w_in_open_nxt;
   logic [1:0]        r_ctrl_q;
   logic [1:0]        r_err;
   logic [1:0]        w_err_set;
   logic              r_tx_valid;
   logic              r_tx_sof;
   logic              r_tx_eof;
   logic [DATA_W-1:0] r_tx_data;
   logic              w_fwd;
   logic              w_fwd_sof;
   logic              w_fwd_eof;
   logic              w_sent_inc;
   logic              w_drop_inc;
   logic              w_tx_en;
   logic              w_cnt_clr;
   logic              w_err_clr;
   a2g_state_t        w_between;
   logic              w_unused_ctrl;

   assign w_tx_en       = ctrl_word[CTRL_TX_EN];
   assign w_cnt_clr     = rise_edge(ctrl_word[CTRL_CNT_CLR], r_ctrl_q[0]);
   assign w_err_clr     = rise_edge(ctrl_word[CTRL_ERR_CLR], r_ctrl_q[1]);
   assign w_between     = w_tx_en ? ST_ARMED : ST_IDLE;
   assign w_len_inc     = r_len + ONE_LEN;
   assign w_unused_ctrl = ^ctrl_word[31:3];

   // Track whether the input stream is inside a frame, so that enabling the gate
   // while a frame is already streaming discards its tail instead of treating it as orphans.
   always_comb begin
      w_in_open_nxt = r_in_open;
      if (in_valid) begin
         if (in_sof) begin
            w_in_open_nxt = ~in_eof;
         end else if (in_eof) begin
            w_in_open_nxt = 1'b0;
         end else begin
            w_in_open_nxt = r_in_open;
         end
      end else begin
         w_in_open_nxt = r_in_open;
      end
   end

   // Next-state, forwarding decision, counter events and error flags for the current word.
   always_comb begin
      w_state_nxt = r_state;
      w_fwd       = 1'b0;
      w_fwd_sof   = 1'b0;
      w_fwd_eof   = 1'b0;
      w_sent_inc  = 1'b0;
      w_drop_inc  = 1'b0;
      w_err_set   = 2'b00;
      w_len_nxt   = r_len;
      case (r_state)
         ST_IDLE: begin
            if (in_valid && in_sof) begin
               w_drop_inc = 1'b1;
            end else begin
               w_drop_inc = 1'b0;
            end
            if (w_tx_en) begin
               if (w_in_open_nxt) begin
                  w_state_nxt = ST_DROP;
               end else begin
                  w_state_nxt = ST_ARMED;
               end
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_ARMED: begin
            w_state_nxt = w_between;
            if (in_valid) begin
               if (in_sof) begin
                  if (tx_ready) begin
                     w_fwd     = 1'b1;
                     w_fwd_sof = 1'b1;
                     w_len_nxt = ONE_LEN;
                     if (in_eof) begin
                        w_fwd_eof  = 1'b1;
                        w_sent_inc = 1'b1;
                     end else begin
                        w_state_nxt = ST_PASS;
                     end
                  end else begin
                     w_drop_inc = 1'b1;
                     if (in_eof) begin
                        w_state_nxt = w_between;
                     end else begin
                        w_state_nxt = ST_DROP;
                     end
                  end
               end else begin
                  // orphan word: only its eof marks a frame that was lost
                  w_drop_inc = in_eof;
               end
            end else begin
               w_state_nxt = w_between;
            end
         end
         ST_PASS: begin
            if (in_valid) begin
               if (in_sof) begin
                  // new frame started before the open one ended: close the open one here
                  w_err_set[ERR_LEN] = 1'b1;
                  if (tx_ready) begin
                     w_fwd      = 1'b1;
                     w_fwd_eof  = 1'b1;
                     w_sent_inc = 1'b1;
                  end else begin
                     w_err_set[ERR_READY] = 1'b1;
                  end
                  if (in_eof) begin
                     w_state_nxt = w_between;
                  end else begin
                     w_state_nxt = ST_DROP;
                  end
               end else if (!tx_ready) begin
                  w_err_set[ERR_READY] = 1'b1;
                  if (in_eof) begin
                     w_state_nxt = w_between;
                  end else begin
                     w_state_nxt = ST_PASS;
                  end
               end else begin
                  w_fwd     = 1'b1;
                  w_len_nxt = w_len_inc;
                  if (in_eof) begin
                     w_fwd_eof   = 1'b1;
                     w_sent_inc  = 1'b1;
                     w_state_nxt = w_between;
                  end else if (w_len_inc == MAX_LEN) begin
                     w_fwd_eof          = 1'b1;
                     w_sent_inc         = 1'b1;
                     w_err_set[ERR_LEN] = 1'b1;
                     w_state_nxt        = ST_DROP;
                  end else begin
                     w_state_nxt = ST_PASS;
                  end
               end
            end else begin
               w_state_nxt = ST_PASS;
            end
         end
         ST_DROP: begin
            if (in_valid && in_eof) begin
               w_state_nxt = w_between;
            end else begin
               w_state_nxt = ST_DROP;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // FSM state, frame length and input-framing tracker.
   always_ff @(posedge user_clk or negedge user_rst_n) begin
      if (!user_rst_n) begin
         r_state   <= ST_IDLE;
         r_len     <= {LEN_W{1'b0}};
         r_in_open <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_len     <= w_len_nxt;
         r_in_open <= w_in_open_nxt;
      end
   end

   // Registered output word: exactly one cycle after acceptance, zero when nothing forwarded.
   always_ff @(posedge user_clk or negedge user_rst_n) begin
      if (!user_rst_n) begin
         r_tx_valid <= 1'b0;
         r_tx_sof   <= 1'b0;
         r_tx_eof   <= 1'b0;
         r_tx_data  <= {DATA_W{1'b0}};
      end else begin
         r_tx_valid <= w_fwd;
         r_tx_sof   <= w_fwd_sof;
         r_tx_eof   <= w_fwd_eof;
         r_tx_data  <= w_fwd ? in_data : {DATA_W{1'b0}};
      end
   end

   // Previous control bits for edge detection, and the sticky error flags (set beats clear).
   always_ff @(posedge user_clk or negedge user_rst_n) begin
      if (!user_rst_n) begin
         r_ctrl_q <= 2'b00;
         r_err    <= 2'b00;
      end else begin
         r_ctrl_q <= {ctrl_word[CTRL_ERR_CLR], ctrl_word[CTRL_CNT_CLR]};
         if (w_err_clr) begin
            r_err <= w_err_set;
         end else begin
            r_err <= r_err | w_err_set;
         end
      end
   end

   a2g_frame_counter #(.CNT_W(CNT_W)) u_sent_cnt (
      .i_clk   (user_clk),
      .i_rst_n (user_rst_n),
      .i_inc   (w_sent_inc),
      .i_clr   (w_cnt_clr),
      .o_count (frames_sent)
   );

   a2g_frame_counter #(.CNT_W(CNT_W)) u_drop_cnt (
      .i_clk   (user_clk),
      .i_rst_n (user_rst_n),
      .i_inc   (w_drop_inc),
      .i_clr   (w_cnt_clr),
      .o_count (frames_drop)
   );

   assign tx_valid   = r_tx_valid;
   assign tx_sof     = r_tx_sof;
   assign tx_eof     = r_tx_eof;
   assign tx_data    = r_tx_data;
   assign err_sticky = r_err;
   assign state_dbg  = r_state;

endmodule

// File: tb/tb_a2g_tx_frame_gate.sv
// Self-checking bench for a2g_tx_frame_gate: a constant vector table, scenario
// sequences with fixed expected totals, and random frames against a frame-level model.
`timescale 1ns/1ps
module tb_a2g_tx_frame_gate;

   localparam int MAXW   = 128;
   localparam int F_NONE = 0;   // between frames
   localparam int F_PASS = 1;   // current frame is being forwarded
   localparam int F_DROP = 2;   // current frame is being discarded

   logic        user_clk = 1'b0;
   logic        user_rst_n = 1'b0;
   logic [31:0] ctrl_word = 32'd0;
   logic        in_valid = 1'b0, in_sof = 1'b0, in_eof = 1'b0, tx_ready = 1'b1;
   logic [63:0] in_data = 64'd0;
   logic        tx_valid, tx_sof, tx_eof;
   logic [63:0] tx_data;
   logic [31:0] frames_sent, frames_drop;
   logic [1:0]  err_sticky, state_dbg;

   int errors = 0;
   int checks = 0;
   int n_out  = 0;
   bit cc = 1'b0, ec = 1'b0;

   // reference model state
   int          m_fate, m_len;
   bit          m_en_q, m_pclr, m_perr;
   logic [31:0] m_sent, m_drop;
   logic [1:0]  m_err;
   bit          e_valid, e_sof, e_eof;
   logic [63:0] e_data;

   typedef struct {
      bit en, v, s, e, r;
      bit xv, xs, xe;
      int xsent, xdrop;
      int xerr;
   } vec_t;
   vec_t tbl[15];

   always #5 user_clk = ~user_clk;

   a2g_tx_frame_gate #(.DATA_W(64), .CNT_W(32), .MAX_FRAME_WORDS(MAXW)) dut (
      .user_clk    (user_clk),
      .user_rst_n  (user_rst_n),
      .ctrl_word   (ctrl_word),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_sof      (in_sof),
      .in_eof      (in_eof),
      .tx_ready    (tx_ready),
      .tx_valid    (tx_valid),
      .tx_data     (tx_data),
      .tx_sof      (tx_sof),
      .tx_eof      (tx_eof),
      .frames_sent (frames_sent),
      .frames_drop (frames_drop),
      .err_sticky  (err_sticky),
      .state_dbg   (state_dbg)
   );

   function automatic vec_t mk(int en, int v, int s, int e, int r,
                               int xv, int xs, int xe, int xsent, int xdrop, int xerr);
      vec_t t;
      t.en = en[0]; t.v = v[0]; t.s = s[0]; t.e = e[0]; t.r = r[0];
      t.xv = xv[0]; t.xs = xs[0]; t.xe = xe[0];
      t.xsent = xsent; t.xdrop = xdrop; t.xerr = xerr;
      return t;
   endfunction

   function automatic logic [63:0] pat(int i);
      return 64'hA5A5_0000_0000_0000 ^ 64'(i);
   endfunction

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Frame-level behaviour: each frame's fate is decided at its sof from the gate
   // enable seen at the previous edge, then the frame runs to its end.
   function automatic void model_step();
      bit set0 = 1'b0, set1 = 1'b0, inc_s = 1'b0, inc_d = 1'b0;
      e_valid = 1'b0; e_sof = 1'b0; e_eof = 1'b0; e_data = 64'd0;
      if (in_valid) begin
         if (m_fate == F_NONE) begin
            if (in_sof) begin
               if (m_en_q && tx_ready) begin
                  e_valid = 1'b1; e_sof = 1'b1; e_data = in_data; m_len = 1;
                  if (in_eof) begin e_eof = 1'b1; inc_s = 1'b1; end
                  else m_fate = F_PASS;
               end else begin
                  inc_d = 1'b1;
                  if (!in_eof) m_fate = F_DROP;
               end
            end else if (in_eof && m_en_q) begin
               inc_d = 1'b1;
            end
         end else if (m_fate == F_PASS) begin
            if (in_sof) begin
               set1 = 1'b1;
               if (tx_ready) begin
                  e_valid = 1'b1; e_eof = 1'b1; e_data = in_data; inc_s = 1'b1;
               end else set0 = 1'b1;
               m_fate = in_eof ? F_NONE : F_DROP;
            end else if (!tx_ready) begin
               set0 = 1'b1;
               if (in_eof) m_fate = F_NONE;
            end else begin
               m_len++;
               e_valid = 1'b1; e_data = in_data;
               if (in_eof) begin
                  e_eof = 1'b1; inc_s = 1'b1; m_fate = F_NONE;
               end else if (m_len == MAXW) begin
                  e_eof = 1'b1; inc_s = 1'b1; set1 = 1'b1; m_fate = F_DROP;
               end
            end
         end else if (in_eof) begin
            m_fate = F_NONE;
         end
      end
      if (ctrl_word[1] && !m_pclr) begin
         m_sent = 32'd0; m_drop = 32'd0;
      end else begin
         if (inc_s) m_sent = m_sent + 32'd1;
         if (inc_d) m_drop = m_drop + 32'd1;
      end
      if (ctrl_word[2] && !m_perr) m_err = {set1, set0};
      else m_err = m_err | {set1, set0};
      m_pclr = ctrl_word[1];
      m_perr = ctrl_word[2];
      m_en_q = ctrl_word[0];
   endfunction

   function automatic void check_outputs();
      chk("tx_valid", 64'(tx_valid), 64'(e_valid));
      if (e_valid) begin
         chk("tx_sof_eof", 64'({tx_sof, tx_eof}), 64'({e_sof, e_eof}));
         chk("tx_data", tx_data, e_data);
      end
      chk("frames_sent", 64'(frames_sent), 64'(m_sent));
      chk("frames_drop", 64'(frames_drop), 64'(m_drop));
      chk("err_sticky", 64'(err_sticky), 64'(m_err));
      if (tx_valid === 1'b1) n_out++;
   endfunction

   // Apply one cycle of input (bits [31:3] of ctrl_word are random junk), then check.
   task automatic cyc(input bit en, input bit v, input bit s, input bit e,
                      input bit r, input logic [63:0] d);
      ctrl_word = {29'($urandom), ec, cc, en};
      in_valid = v; in_sof = s; in_eof = e; tx_ready = r; in_data = d;
      model_step();
      @(posedge user_clk); #1;
      check_outputs();
   endtask

   task automatic do_reset();
      @(posedge user_clk); #1;
      user_rst_n = 1'b0;
      #1;
      chk("rst_ctl", 64'({tx_valid, tx_sof, tx_eof, err_sticky, state_dbg}), 64'd0);
      chk("rst_data", tx_data, 64'd0);
      chk("rst_cnt", {frames_sent, frames_drop}, 64'd0);
      in_valid = 1'b0; cc = 1'b0; ec = 1'b0;
      repeat (2) @(posedge user_clk);
      #1;
      user_rst_n = 1'b1;
      m_fate = F_NONE; m_len = 0; m_en_q = 1'b0; m_pclr = 1'b0; m_perr = 1'b0;
      m_sent = 32'd0; m_drop = 32'd0; m_err = 2'b00; n_out = 0;
   endtask

   initial begin
      bit en_r;
      int len, gap;
      //               en v s e r  xv xs xe sent drop err
      tbl[0]  = mk(1, 0, 0, 0, 1,  0, 0, 0,  0, 0, 0);
      tbl[1]  = mk(1, 1, 1, 1, 1,  1, 1, 1,  1, 0, 0);
      tbl[2]  = mk(1, 1, 1, 0, 0,  0, 0, 0,  1, 1, 0);
      tbl[3]  = mk(1, 1, 0, 1, 1,  0, 0, 0,  1, 1, 0);
      tbl[4]  = mk(1, 1, 0, 1, 1,  0, 0, 0,  1, 2, 0);
      tbl[5]  = mk(1, 1, 1, 0, 1,  1, 1, 0,  1, 2, 0);
      tbl[6]  = mk(0, 1, 0, 0, 1,  1, 0, 0,  1, 2, 0);
      tbl[7]  = mk(0, 1, 0, 1, 1,  1, 0, 1,  2, 2, 0);
      tbl[8]  = mk(0, 1, 1, 1, 1,  0, 0, 0,  2, 3, 0);
      tbl[9]  = mk(0, 1, 1, 0, 1,  0, 0, 0,  2, 4, 0);
      tbl[10] = mk(1, 1, 0, 0, 1,  0, 0, 0,  2, 4, 0);
      tbl[11] = mk(1, 1, 0, 1, 1,  0, 0, 0,  2, 4, 0);
      tbl[12] = mk(1, 1, 1, 0, 1,  1, 1, 0,  2, 4, 0);
      tbl[13] = mk(1, 1, 1, 1, 1,  1, 0, 1,  3, 4, 2);
      tbl[14] = mk(1, 0, 0, 0, 1,  0, 0, 0,  3, 4, 2);

      do_reset();
      for (int i = 0; i < 15; i++) begin
         cyc(tbl[i].en, tbl[i].v, tbl[i].s, tbl[i].e, tbl[i].r, pat(i));
         chk("tbl_flags", 64'({tx_valid, tx_sof, tx_eof}), 64'({tbl[i].xv, tbl[i].xs, tbl[i].xe}));
         if (tbl[i].xv) chk("tbl_data", tx_data, pat(i));
         chk("tbl_sent", 64'(frames_sent), 64'(tbl[i].xsent));
         chk("tbl_drop", 64'(frames_drop), 64'(tbl[i].xdrop));
         chk("tbl_err", 64'(err_sticky), 64'(tbl[i].xerr));
      end

      // three 100-word frames straight through
      do_reset();
      cyc(1, 0, 0, 0, 1, 64'd0);
      for (int f = 0; f < 3; f++)
         for (int i = 0; i < 100; i++) cyc(1, 1, i == 0, i == 99, 1, pat(f * 100 + i));
      chk("t1_words", 64'(n_out), 64'd300);
      chk("t1_sent", 64'(frames_sent), 64'd3);
      chk("t1_drop", 64'(frames_drop), 64'd0);

      // tx_en falls at word 50: frame completes, next frame dropped
      do_reset();
      cyc(1, 0, 0, 0, 1, 64'd0);
      for (int i = 0; i < 100; i++) cyc(i < 49, 1, i == 0, i == 99, 1, pat(i));
      for (int i = 0; i < 10; i++) cyc(0, 1, i == 0, i == 9, 1, pat(i));
      chk("t2_words", 64'(n_out), 64'd100);
      chk("t2_sent", 64'(frames_sent), 64'd1);
      chk("t2_drop", 64'(frames_drop), 64'd1);
      chk("t2_state", 64'(state_dbg), 64'd0);

      // tx_en rises mid-frame: tail discarded, next frame passes
      do_reset();
      cyc(0, 0, 0, 0, 1, 64'd0);
      for (int i = 0; i < 20; i++) cyc(i >= 10, 1, i == 0, i == 19, 1, pat(i));
      chk("t3_drop_mid", 64'(frames_drop), 64'd1);
      for (int i = 0; i < 20; i++) cyc(1, 1, i == 0, i == 19, 1, pat(i));
      chk("t3_sent", 64'(frames_sent), 64'd1);
      chk("t3_drop", 64'(frames_drop), 64'd1);
      chk("t3_words", 64'(n_out), 64'd20);

      // 200-word frame force-terminated at word 128, then err_clr
      do_reset();
      cyc(1, 0, 0, 0, 1, 64'd0);
      for (int i = 0; i < 200; i++) begin
         cyc(1, 1, i == 0, i == 199, 1, pat(i));
         if (i == 127) chk("t4_eof128", 64'({tx_valid, tx_eof}), 64'd3);
      end
      for (int i = 0; i < 10; i++) cyc(1, 1, i == 0, i == 9, 1, pat(i));
      chk("t4_words", 64'(n_out), 64'd138);
      chk("t4_sent", 64'(frames_sent), 64'd2);
      chk("t4_err", 64'(err_sticky), 64'd2);
      ec = 1'b1; cyc(1, 0, 0, 0, 1, 64'd0);
      ec = 1'b0; cyc(1, 0, 0, 0, 1, 64'd0);
      chk("t4_err_clr", 64'(err_sticky), 64'd0);

      // not ready at sof, then not ready for one mid-frame cycle
      do_reset();
      cyc(1, 0, 0, 0, 1, 64'd0);
      for (int i = 0; i < 100; i++) cyc(1, 1, i == 0, i == 99, i != 0, pat(i));
      chk("t5_drop", 64'(frames_drop), 64'd1);
      chk("t5_words0", 64'(n_out), 64'd0);
      for (int i = 0; i < 100; i++) cyc(1, 1, i == 0, i == 99, i != 50, pat(i));
      chk("t5_words", 64'(n_out), 64'd99);
      chk("t5_err", 64'(err_sticky), 64'd1);
      chk("t5_sent", 64'(frames_sent), 64'd1);

      // counter clear colliding with eof, then reset mid-frame
      do_reset();
      cyc(1, 0, 0, 0, 1, 64'd0);
      for (int i = 0; i < 10; i++) begin
         cc = (i == 9);
         cyc(1, 1, i == 0, i == 9, 1, pat(i));
      end
      cc = 1'b0;
      chk("t6_clr_sent", 64'(frames_sent), 64'd0);
      for (int i = 0; i < 10; i++) cyc(1, 1, i == 0, 0, 1, pat(i));
      do_reset();
      for (int i = 10; i < 20; i++) cyc(1, 1, 0, i == 19, 1, pat(i));
      for (int i = 0; i < 10; i++) cyc(1, 1, i == 0, i == 9, 1, pat(i));
      chk("t6_sent", 64'(frames_sent), 64'd1);
      chk("t6_drop", 64'(frames_drop), 64'd1);
      chk("t6_words", 64'(n_out), 64'd10);

      // random well-formed frames, random enable/ready/clears, unqualified junk on idle cycles
      do_reset();
      en_r = 1'b1;
      for (int f = 0; f < 40; f++) begin
         len = $urandom_range(1, 160);
         gap = $urandom_range(0, 3);
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 19) == 0) en_r = ~en_r;
            cc = ($urandom_range(0, 29) == 0);
            ec = ($urandom_range(0, 29) == 0);
            cyc(en_r, 1, i == 0, i == len - 1, $urandom_range(0, 15) != 0,
                {$urandom, $urandom});
         end
         for (int g = 0; g < gap; g++)
            cyc(en_r, 0, 1'($urandom), 1'($urandom), 1'($urandom), {$urandom, $urandom});
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
